// File: rtl/predictor_gshare.sv
// predictor_gshare: gshare / bimodal branch direction predictor.
//   A table of 2^PHT_WIDTH two-bit saturating counters is indexed by
//   PC[PHT_WIDTH+1:2], optionally XORed with a global history register.
//   After reset the table is walked one entry per cycle to CNT_INIT
//   before lookups and updates are accepted.
// Ports:
//   clockIn, resetIn            rising-edge clock, synchronous active-low reset
//   ready                       table initialised, requests accepted
//   instrInValid, instrAddr     lookup request
//   jumpValid, jump, predHistory  prediction one cycle after lookup
//   updateValid, updateInstr,   branch commit: PC, history snapshot used at
//   updateHistory, taken        prediction time, and resolved outcome
module predictor_gshare #(
  parameter int unsigned PHT_WIDTH = 12,
  parameter int unsigned GHR_WIDTH = 8,
  parameter int unsigned MODE      = 1,
  parameter logic [1:0]  CNT_INIT  = 2'b01
) (
  input  logic                 clockIn,
  input  logic                 resetIn,
  output logic                 ready,
  input  logic                 instrInValid,
  input  logic [31:0]          instrAddr,
  output logic                 jumpValid,
  output logic                 jump,
  output logic [GHR_WIDTH-1:0] predHistory,
  input  logic                 updateValid,
  input  logic [31:0]          updateInstr,
  input  logic [GHR_WIDTH-1:0] updateHistory,
  input  logic                 taken
);

  localparam int unsigned PHT_ENTRIES = 1 << PHT_WIDTH;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [PHT_WIDTH-1:0] ptr_q, ptr_d;
  logic [GHR_WIDTH-1:0] ghr_q, ghr_d;
  logic                 ready_q, ready_d;
  logic                 jv_q, jv_d;
  logic                 jump_q, jump_d;
  logic [GHR_WIDTH-1:0] ph_q, ph_d;

  logic [1:0]           pht_q [PHT_ENTRIES];
  logic                 pht_we;
  logic [PHT_WIDTH-1:0] pht_waddr;
  logic [1:0]           pht_wdata;

  logic [PHT_WIDTH-1:0] lk_idx;
  logic [PHT_WIDTH-1:0] up_idx;
  logic [1:0]           up_cnt;
  logic [1:0]           up_next;

  // Address bits outside the index field are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{instrAddr[31:PHT_WIDTH+2], instrAddr[1:0],
                         updateInstr[31:PHT_WIDTH+2], updateInstr[1:0],
                         updateHistory};

  // Index hash; update side uses the history captured at prediction time.
  generate
    if (MODE == 1) begin : g_gshare
      assign lk_idx = instrAddr[PHT_WIDTH+1:2]   ^ PHT_WIDTH'(ghr_q);
      assign up_idx = updateInstr[PHT_WIDTH+1:2] ^ PHT_WIDTH'(updateHistory);
    end else begin : g_bimodal
      assign lk_idx = instrAddr[PHT_WIDTH+1:2];
      assign up_idx = updateInstr[PHT_WIDTH+1:2];
    end
  endgenerate

  // Saturating counter step.
  assign up_cnt = pht_q[up_idx];
  always_comb begin
    up_next = up_cnt;
    if (taken) begin
      if (up_cnt != 2'b11) up_next = 2'(up_cnt + 2'd1);
    end else begin
      if (up_cnt != 2'b00) up_next = 2'(up_cnt - 2'd1);
    end
  end

  // State and output registers.
  always_ff @(posedge clockIn) begin
    if (!resetIn) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
      ghr_q   <= '0;
      ready_q <= 1'b0;
      jv_q    <= 1'b0;
      jump_q  <= 1'b0;
      ph_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ghr_q   <= ghr_d;
      ready_q <= ready_d;
      jv_q    <= jv_d;
      jump_q  <= jump_d;
      ph_q    <= ph_d;
    end
  end

  // Counter table: single write port shared by init walk and commit.
  always_ff @(posedge clockIn) begin
    if (pht_we && resetIn) begin
      pht_q[pht_waddr] <= pht_wdata;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    ghr_d     = ghr_q;
    ready_d   = ready_q;
    jv_d      = 1'b0;
    jump_d    = jump_q;
    ph_d      = ph_q;
    pht_we    = 1'b0;
    pht_waddr = ptr_q;
    pht_wdata = CNT_INIT;

    case (state_q)
      ST_INIT: begin
        ready_d   = 1'b0;
        pht_we    = 1'b1;
        pht_waddr = ptr_q;
        pht_wdata = CNT_INIT;
        ptr_d     = PHT_WIDTH'(ptr_q + PHT_WIDTH'(1));
        if (&ptr_q) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end
      end
      ST_RUN: begin
        ready_d = 1'b1;
        // Lookup sees pre-update counter and pre-shift history.
        if (instrInValid) begin
          jv_d   = 1'b1;
          jump_d = pht_q[lk_idx][1];
          ph_d   = ghr_q;
        end
        if (updateValid) begin
          pht_we    = 1'b1;
          pht_waddr = up_idx;
          pht_wdata = up_next;
          ghr_d     = GHR_WIDTH'((ghr_q << 1) | GHR_WIDTH'(taken));
        end
      end
      default: begin
        state_d = ST_INIT;
        ptr_d   = '0;
        ready_d = 1'b0;
      end
    endcase
  end

  assign ready       = ready_q;
  assign jumpValid   = jv_q;
  assign jump        = jump_q;
  assign predHistory = ph_q;

endmodule

// File: doc/predictor_gshare.md
PREDICTOR_GSHARE -- requirements
Module: predictor_gshare

Interface
REQ-001 SHALL have parameter PHT_WIDTH, default 12, log2 of pattern-history-table entries.
REQ-002 SHALL have parameter GHR_WIDTH, default 8, global history length; legal range 1..PHT_WIDTH.
REQ-003 SHALL have parameter MODE, default 1: 0 = bimodal (PC index only), 1 = gshare (PC XOR history).
REQ-004 SHALL have parameter CNT_INIT, default 2'b01, counter value written at initialisation.
REQ-005 SHALL have one clock and a synchronous active-low reset: clockIn input 1, rising-edge clock; resetIn input 1, synchronous active-low reset.
REQ-006 ready  output  1  table initialised, lookups/updates accepted.
REQ-007 instrInValid  input  1  lookup request (icache).
REQ-008 instrAddr  input  32  lookup PC.
REQ-009 jumpValid  output  1  prediction valid this cycle.
REQ-010 jump  output  1  predicted taken.
REQ-011 predHistory  output  GHR_WIDTH  GHR snapshot used for this prediction; carried by Reorder Buffer.
REQ-012 updateValid  input  1  branch commit (Reorder Buffer).
REQ-013 updateInstr  input  32  committed branch PC.
REQ-014 updateHistory  input  GHR_WIDTH  predHistory value returned with the committed branch.
REQ-015 taken  input  1  committed branch outcome.

Function
REQ-016 Storage SHALL be 2^PHT_WIDTH two-bit saturating counters plus a GHR_WIDTH-bit global history register (GHR).
REQ-017 FSM SHALL have states INIT and RUN; reset enters INIT with init pointer 0.
REQ-018 In INIT, one entry per cycle SHALL be written with CNT_INIT, pointer incrementing; after writing entry 2^PHT_WIDTH-1 the FSM SHALL enter RUN.
REQ-019 ready SHALL be registered, 0 in INIT, 1 in RUN; first ready=1 cycle SHALL be exactly 2^PHT_WIDTH cycles after the last reset-asserted cycle.
REQ-020 While ready=0, instrInValid and updateValid SHALL be ignored (no table/GHR change, jumpValid stays 0).
REQ-021 Lookup index: MODE 0 = instrAddr[PHT_WIDTH+1:2]; MODE 1 = instrAddr[PHT_WIDTH+1:2] XOR GHR zero-extended at MSBs to PHT_WIDTH.
REQ-022 Update index: same function on updateInstr and updateHistory (not current GHR).
REQ-023 Lookup latency SHALL be 1 cycle: instrInValid=1 with ready=1 in cycle N gives jumpValid=1 in N+1, jump = counter[1] and predHistory = GHR as sampled in cycle N.
REQ-024 Without a lookup in cycle N, jumpValid SHALL be 0 in N+1; jump and predHistory SHALL hold last values.
REQ-025 Counter update on updateValid: taken increments, not-taken decrements, saturating at 2'b11 and 2'b00 (no wrap).
REQ-026 On updateValid (RUN), GHR SHALL shift left by one, taken inserted at bit 0, MSB discarded; GHR changes only at commit.
REQ-027 Lookup and update in the same cycle: lookup SHALL read pre-update counter and pre-shift GHR; update SHALL complete.
REQ-028 Back-to-back updates to one index on consecutive cycles SHALL each apply (no lost increments).
REQ-029 Lookups SHALL be accepted every cycle (throughput 1/cycle).

Reset
REQ-030 On resetIn=0 at a clock edge: state INIT, pointer 0, GHR 0, ready 0, jumpValid 0, jump 0, predHistory 0.
REQ-031 Reset asserted mid-INIT or mid-RUN SHALL restart initialisation from entry 0; prior counter contents SHALL NOT be observable afterwards.

Verification (PHT_WIDTH=4, GHR_WIDTH=2)
REQ-032 Reset 1 cycle, then lookup 0x40 each cycle -> ready=0 for 16 cycles, ready=1 on 17th; first prediction jump=0, predHistory=2'b00.
REQ-033 MODE 0: 6 taken updates at 0x40, then 1 not-taken -> lookup 0x40 gives jump=1 (counter 11 then 10, no wrap).
REQ-034 MODE 0: 3 not-taken then 2 taken at 0x44 -> counter 01->00->00->00->01->10; lookup gives jump=0 after 4th update, jump=1 after 5th.
REQ-035 MODE 1: commit taken,taken (GHR=2'b11), then 2 taken updates at 0x40 with updateHistory=2'b11 -> lookup 0x40 reads index 3, jump=1, predHistory=2'b11; lookup 0x4C (index 0) gives jump=0.
REQ-036 Same-cycle lookup 0x40 and taken update at 0x40 (MODE 0, counter 01) -> jump=0 next cycle; repeat lookup -> jump=1.
REQ-037 Reset during RUN after training -> ready drops next cycle, GHR=0, and after 16 cycles lookup 0x40 gives jump=0.
